// File: rtl/imm_decode_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_decode_stage : registered RV immediate decoder with 2-entry skid buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
module imm_decode_stage #(
   parameter int XLEN   = 32,
   parameter int TAG_W  = 32,
   parameter int EN_CSR = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [2:0] c_FMT_NONE = 3'd0;
   localparam logic [2:0] c_FMT_I    = 3'd1;
   localparam logic [2:0] c_FMT_S    = 3'd2;
   localparam logic [2:0] c_FMT_B    = 3'd3;
   localparam logic [2:0] c_FMT_U    = 3'd4;
   localparam logic [2:0] c_FMT_J    = 3'd5;
   localparam logic [2:0] c_FMT_Z    = 3'd6;
   localparam logic [2:0] c_FMT_SH   = 3'd7;

   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] c_OP_REG    = 7'b0110011;
   localparam logic [6:0] c_OP_REG_32 = 7'b0111011;
   localparam logic [6:0] c_OP_FENCE  = 7'b0001111;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [XLEN-1:0]  dec_imm;
   logic [2:0]       dec_fmt;
   logic             dec_illegal;

   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q, out_imm_d;
   logic [2:0]       out_fmt_q, out_fmt_d;
   logic             out_illegal_q, out_illegal_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic [2:0]       skid_fmt_q, skid_fmt_d;
   logic             skid_illegal_q, skid_illegal_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];

   always_comb begin
      dec_imm     = '0;
      dec_fmt     = c_FMT_NONE;
      dec_illegal = 1'b0;
      case (opcode)
         c_OP_IMM: begin
            if (funct3[1:0] == 2'b01) begin
               dec_fmt     = c_FMT_SH;
               dec_imm     = XLEN'(in_instr[25:20]);
               dec_illegal = (XLEN == 32) && in_instr[25];
            end else begin
               dec_fmt = c_FMT_I;
               dec_imm = XLEN'($signed(in_instr[31:20]));
            end
         end
         c_OP_IMM_32: begin
            if (XLEN == 64) begin
               if (funct3[1:0] == 2'b01) begin
                  dec_fmt     = c_FMT_SH;
                  dec_imm     = XLEN'(in_instr[24:20]);
                  dec_illegal = in_instr[25];
               end else begin
                  dec_fmt = c_FMT_I;
                  dec_imm = XLEN'($signed(in_instr[31:20]));
               end
            end else begin
               dec_illegal = 1'b1;
            end
         end
         c_OP_LOAD, c_OP_JALR: begin
            dec_fmt = c_FMT_I;
            dec_imm = XLEN'($signed(in_instr[31:20]));
         end
         c_OP_STORE: begin
            dec_fmt = c_FMT_S;
            dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         end
         c_OP_BRANCH: begin
            dec_fmt = c_FMT_B;
            dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
         end
         c_OP_JAL: begin
            dec_fmt = c_FMT_J;
            dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
         end
         c_OP_LUI, c_OP_AUIPC: begin
            dec_fmt = c_FMT_U;
            dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
         end
         c_OP_SYSTEM: begin
            if ((EN_CSR != 0) && funct3[2]) begin
               dec_fmt = c_FMT_Z;
               dec_imm = XLEN'(in_instr[19:15]);
            end
         end
         c_OP_REG, c_OP_REG_32, c_OP_FENCE: begin
            dec_illegal = 1'b0;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Skid is only ever loaded while the output register holds and does not drain;
   // once occupied, in_ready drops so the skid cannot be overwritten.
   always_comb begin
      out_valid_d    = out_valid_q;
      out_imm_d      = out_imm_q;
      out_fmt_d      = out_fmt_q;
      out_illegal_d  = out_illegal_q;
      out_tag_d      = out_tag_q;
      skid_valid_d   = skid_valid_q;
      skid_imm_d     = skid_imm_q;
      skid_fmt_d     = skid_fmt_q;
      skid_illegal_d = skid_illegal_q;
      skid_tag_d     = skid_tag_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_valid_d   = 1'b1;
            out_imm_d     = skid_imm_q;
            out_fmt_d     = skid_fmt_q;
            out_illegal_d = skid_illegal_q;
            out_tag_d     = skid_tag_q;
            skid_valid_d  = 1'b0;
         end else if (in_valid) begin
            out_valid_d   = 1'b1;
            out_imm_d     = dec_imm;
            out_fmt_d     = dec_fmt;
            out_illegal_d = dec_illegal;
            out_tag_d     = in_tag;
         end else begin
            out_valid_d   = 1'b0;
         end
      end else if (in_valid && !skid_valid_q) begin
         skid_valid_d   = 1'b1;
         skid_imm_d     = dec_imm;
         skid_fmt_d     = dec_fmt;
         skid_illegal_d = dec_illegal;
         skid_tag_d     = in_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q    <= 1'b0;
         out_imm_q      <= '0;
         out_fmt_q      <= c_FMT_NONE;
         out_illegal_q  <= 1'b0;
         out_tag_q      <= '0;
         skid_valid_q   <= 1'b0;
         skid_imm_q     <= '0;
         skid_fmt_q     <= c_FMT_NONE;
         skid_illegal_q <= 1'b0;
         skid_tag_q     <= '0;
      end else begin
         out_valid_q    <= out_valid_d;
         out_imm_q      <= out_imm_d;
         out_fmt_q      <= out_fmt_d;
         out_illegal_q  <= out_illegal_d;
         out_tag_q      <= out_tag_d;
         skid_valid_q   <= skid_valid_d;
         skid_imm_q     <= skid_imm_d;
         skid_fmt_q     <= skid_fmt_d;
         skid_illegal_q <= skid_illegal_d;
         skid_tag_q     <= skid_tag_d;
      end
   end

   assign in_ready    = ~skid_valid_q;
   assign out_valid   = out_valid_q;
   assign out_imm     = out_imm_q;
   assign out_fmt     = out_fmt_q;
   assign out_illegal = out_illegal_q;
   assign out_tag     = out_tag_q;

endmodule
`default_nettype wire
